// File: rtl/lc3_mem_access_pkg.sv
// rtl/lc3_mem_access_pkg.sv - shared types and reset constants for the LC3 memory-access stage
package lc3_mem_pkg;

    localparam int LC3_WORD_W = 16;

    typedef enum logic [2:0] {
        MEM_IDLE   = 3'd0,
        MEM_IND_RD = 3'd1,
        MEM_RD     = 3'd2,
        MEM_WR     = 3'd3,
        MEM_DONE   = 3'd4
    } lc3_mem_state_e;

    localparam logic [LC3_WORD_W-1:0] RST_DATA_ADDR = '0;
    localparam logic [LC3_WORD_W-1:0] RST_DATA_DIN  = '0;
    localparam logic                  RST_DATA_RD   = 1'b1;
    localparam logic [LC3_WORD_W-1:0] RST_MEMOUT    = '0;

    function automatic logic is_phase(input lc3_mem_state_e s);
        return (s == MEM_IND_RD) || (s == MEM_RD) || (s == MEM_WR);
    endfunction

endpackage

// File: rtl/lc3_mem_access_if.sv
// rtl/lc3_mem_access_if.sv - data-memory port between the memory-access stage and its responder
interface lc3_mem_access_if;
    import lc3_mem_pkg::*;

    logic [LC3_WORD_W-1:0] Data_addr;
    logic [LC3_WORD_W-1:0] Data_din;
    logic                  Data_rd;
    logic [LC3_WORD_W-1:0] Data_dout;
    logic                  complete_data;

    modport master (
        output Data_addr, Data_din, Data_rd,
        input  Data_dout, complete_data
    );

    modport slave (
        input  Data_addr, Data_din, Data_rd,
        output Data_dout, complete_data
    );

endinterface

// File: rtl/lc3_mem_access_watchdog.sv
// rtl/lc3_mem_access_watchdog.sv - per-phase wait counter, used only when LC3_MEM_TIMEOUT_EN is defined
module lc3_mem_watchdog #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic phase_active,
    input  logic complete,
    output logic timeout
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] wait_cnt;

    // A completing phase hands over to the next phase, so the count restarts there.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_cnt <= '0;
        end else if (!phase_active || complete) begin
            wait_cnt <= '0;
        end else if (!timeout) begin
            wait_cnt <= wait_cnt + CNT_W'(1);
        end
    end

    assign timeout = phase_active && !complete && (wait_cnt == LAST_WAIT);

endmodule

// File: rtl/lc3_mem_access.sv
// rtl/lc3_mem_access.sv - LC3 memory-access stage FSM; LC3_MEM_TIMEOUT_EN adds a per-phase abort
module lc3_mem_access
    import lc3_mem_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  mem_start,
    input  logic                  mem_store,
    input  logic                  Mem_Control,
    input  logic [LC3_WORD_W-1:0] M_addr,
    input  logic [LC3_WORD_W-1:0] M_data,
    lc3_mem_access_if.master      mem,
    output logic [LC3_WORD_W-1:0] memout,
    output logic                  mem_done,
    output logic                  mem_busy,
    output logic                  mem_error
);

    lc3_mem_state_e state_q, state_d;

    logic [LC3_WORD_W-1:0] addr_q, addr_d;
    logic [LC3_WORD_W-1:0] din_q, din_d;
    logic [LC3_WORD_W-1:0] memout_q, memout_d;
    logic                  rd_q, rd_d;
    logic                  done_q, done_d;
    logic                  busy_q, busy_d;
    logic                  store_q, store_d;
    logic                  error_q, error_d;
    logic                  timeout;

`ifdef LC3_MEM_TIMEOUT_EN
    lc3_mem_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk          (clk),
        .reset        (reset),
        .phase_active (busy_q),
        .complete     (mem.complete_data),
        .timeout      (timeout)
    );
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
    assign timeout            = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= MEM_IDLE;
            addr_q   <= RST_DATA_ADDR;
            din_q    <= RST_DATA_DIN;
            rd_q     <= RST_DATA_RD;
            memout_q <= RST_MEMOUT;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
            store_q  <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            din_q    <= din_d;
            rd_q     <= rd_d;
            memout_q <= memout_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
            store_q  <= store_d;
            error_q  <= error_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            MEM_IDLE: begin
                if (mem_start) begin
                    if (Mem_Control)    state_d = MEM_IND_RD;
                    else if (mem_store) state_d = MEM_WR;
                    else                state_d = MEM_RD;
                end
            end
            MEM_IND_RD: begin
                if (timeout)                state_d = MEM_IDLE;
                else if (mem.complete_data) state_d = store_q ? MEM_WR : MEM_RD;
            end
            MEM_RD, MEM_WR: begin
                if (timeout)                state_d = MEM_IDLE;
                else if (mem.complete_data) state_d = MEM_DONE;
            end
            MEM_DONE: state_d = MEM_IDLE;
            default:  state_d = MEM_IDLE;
        endcase
    end

    // Outputs are computed from the upcoming state so that every port comes straight off a flop.
    always_comb begin
        addr_d   = addr_q;
        din_d    = din_q;
        memout_d = memout_q;
        store_d  = store_q;
        error_d  = error_q | timeout;

        if (state_q == MEM_IDLE && mem_start) begin
            addr_d  = M_addr;
            din_d   = M_data;
            store_d = mem_store;
        end
        if (state_q == MEM_IND_RD && mem.complete_data && !timeout) begin
            addr_d = mem.Data_dout;
        end
        if (state_q == MEM_RD && mem.complete_data && !timeout) begin
            memout_d = mem.Data_dout;
        end

        rd_d   = (state_d != MEM_WR);
        busy_d = is_phase(state_d);
        done_d = (state_d == MEM_DONE);
    end

    assign mem.Data_addr = addr_q;
    assign mem.Data_din  = din_q;
    assign mem.Data_rd   = rd_q;
    assign memout        = memout_q;
    assign mem_done      = done_q;
    assign mem_busy      = busy_q;
    assign mem_error     = error_q;

endmodule

// File: tb/tb_lc3_mem_access.sv
// tb/tb_lc3_mem_access.sv - scoreboard bench for lc3_mem_access with a behavioural memory model
module tb_lc3_mem_access;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        mem_start = 1'b0, mem_store = 1'b0, Mem_Control = 1'b0;
    logic [15:0] M_addr = '0, M_data = '0;
    logic [15:0] memout;
    logic        mem_done, mem_busy, mem_error;

    lc3_mem_access_if bus();

    lc3_mem_access #(.TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .reset(reset), .mem_start(mem_start), .mem_store(mem_store),
        .Mem_Control(Mem_Control), .M_addr(M_addr), .M_data(M_data), .mem(bus),
        .memout(memout), .mem_done(mem_done), .mem_busy(mem_busy), .mem_error(mem_error)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0, n_fail = 0;
    logic [15:0] dmem    [0:65535];
    logic [15:0] ref_mem [0:65535];
    int  wait_n = 0;
    bit  force_idle_cpl = 0;
    int  err_cyc = -1;

    typedef struct { logic [15:0] memout; int done_cyc; } exp_t;
    typedef struct { logic [15:0] addr; logic [15:0] data; } wexp_t;
    exp_t  sbq[$];
    wexp_t wq[$];
    logic [15:0] last_load = '0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic flag(input string nm);
        n_chk++;
        n_fail++;
        $display("FAIL %s (cycle %0d)", nm, cyc);
    endtask

    // Memory responder: wait_n low cycles per phase, then one complete cycle.
    initial begin
        int wc;
        wc = 0;
        bus.complete_data = 1'b0;
        bus.Data_dout = '0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                bus.complete_data = 1'b0;
                wc = 0;
            end else begin
                if (bus.complete_data) wc = 0;
                if (mem_busy) begin
                    if (wc < wait_n) begin
                        bus.complete_data = 1'b0;
                        wc++;
                    end else begin
                        bus.complete_data = 1'b1;
                        if (bus.Data_rd) bus.Data_dout = dmem[bus.Data_addr];
                        else             dmem[bus.Data_addr] = bus.Data_din;
                    end
                end else begin
                    bus.complete_data = force_idle_cpl;
                    bus.Data_dout = 16'($urandom);
                    wc = 0;
                end
            end
        end
    end

    // Monitor: pops expectations whenever the DUT completes an access or commits a write.
    initial begin
        logic pb, pc, pr;
        logic [15:0] pa, pd;
        exp_t  e;
        wexp_t w;
        pb = 0; pc = 0; pr = 1; pa = '0; pd = '0;
        forever begin
            @(negedge clk);
            #1;
            if (reset) begin
                if (mem_done) begin
                    if (sbq.size() == 0) flag("unexpected_mem_done");
                    else begin
                        e = sbq.pop_front();
                        check("memout", memout, e.memout);
                        check("done_cycle", cyc, e.done_cyc);
                        check("busy_in_done", mem_busy, 1'b0);
                    end
                end
                if (mem_busy && bus.complete_data && !bus.Data_rd) begin
                    if (wq.size() == 0) flag("unexpected_write");
                    else begin
                        w = wq.pop_front();
                        check("write_addr", bus.Data_addr, w.addr);
                        check("write_data", bus.Data_din, w.data);
                    end
                end
                if (pb && mem_busy && !pc)
                    check("bus_stable", {bus.Data_rd, bus.Data_din, bus.Data_addr}, {pr, pd, pa});
                if (!mem_busy) check("rd_high_when_idle", bus.Data_rd, 1'b1);
                check("mem_error", mem_error, (err_cyc >= 0 && cyc >= err_cyc) ? 1'b1 : 1'b0);
            end
            pb = mem_busy; pc = bus.complete_data; pr = bus.Data_rd;
            pa = bus.Data_addr; pd = bus.Data_din;
        end
    end

    task automatic issue(input bit st, input bit ind, input logic [15:0] a,
                         input logic [15:0] d, input int w, input bit track);
        exp_t  e;
        wexp_t we;
        logic [15:0] ea;
        wait_n = w;
        @(negedge clk);
        mem_start = 1'b1; mem_store = st; Mem_Control = ind; M_addr = a; M_data = d;
        if (track) begin
            ea = ind ? ref_mem[a] : a;
            if (st) begin
                ref_mem[ea] = d;
                we.addr = ea; we.data = d;
                wq.push_back(we);
            end else begin
                last_load = ref_mem[ea];
            end
            e.memout = last_load;
            e.done_cyc = cyc + (ind ? 3 : 2) + w * (ind ? 2 : 1);
            sbq.push_back(e);
        end
        @(negedge clk);
        mem_start = 1'b0; mem_store = 1'($urandom); Mem_Control = 1'($urandom);
        M_addr = 16'($urandom); M_data = 16'($urandom);
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((sbq.size() != 0 || mem_busy) && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (t >= 300) flag("drain_timeout");
        @(negedge clk);
    endtask

    task automatic poke(input logic [15:0] a, input logic [15:0] v);
        dmem[a] = v;
        ref_mem[a] = v;
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout (cycle %0d)", cyc);
        $fatal(1, "bench time limit");
    end

    initial begin
        logic [15:0] v;
        int t;
        for (int i = 0; i < 65536; i++) begin
            v = 16'($urandom);
            dmem[i] = v;
            ref_mem[i] = v;
        end

        repeat (2) @(negedge clk);
        #1;
        check("rst_addr", bus.Data_addr, 16'h0);
        check("rst_din", bus.Data_din, 16'h0);
        check("rst_rd", bus.Data_rd, 1'b1);
        check("rst_memout", memout, 16'h0);
        check("rst_done", mem_done, 1'b0);
        check("rst_busy", mem_busy, 1'b0);
        check("rst_error", mem_error, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        poke(16'h3010, 16'hBEEF);
        issue(0, 0, 16'h3010, 16'h0, 0, 1);
        #1;
        check("ld_phase_addr", bus.Data_addr, 16'h3010);
        check("ld_phase_rd", bus.Data_rd, 1'b1);
        check("ld_phase_busy", mem_busy, 1'b1);
        drain();

        poke(16'h3020, 16'h4000);
        issue(1, 1, 16'h3020, 16'h1234, 0, 1);
        drain();
        check("sti_mem", dmem[16'h4000], 16'h1234);

        poke(16'h3030, 16'h5000);
        poke(16'h5000, 16'hCAFE);
        issue(0, 1, 16'h3030, 16'h0, 3, 1);
        drain();

        issue(0, 0, 16'h3010, 16'h0, 3, 1);
        @(negedge clk);
        mem_start = 1'b1; mem_store = 1'b1; Mem_Control = 1'b1; M_addr = 16'h5555;
        @(negedge clk);
        mem_start = 1'b0;
        drain();

        force_idle_cpl = 1'b1;
        repeat (4) begin
            @(negedge clk);
            #1;
            check("idle_cpl_busy", mem_busy, 1'b0);
        end
        force_idle_cpl = 1'b0;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 40; i++) begin
            issue(1'($urandom), 1'($urandom), 16'($urandom), 16'($urandom),
                  $urandom_range(0, 3), 1);
            drain();
        end

        issue(1, 0, 16'h3100, 16'hAAAA, 6, 0);
        t = 0;
        while (bus.Data_rd && t < 10) begin
            @(negedge clk);
            t++;
        end
        check("reached_wr", bus.Data_rd, 1'b0);
        #2 reset = 1'b0;
        #1;
        check("mid_rst_addr", bus.Data_addr, 16'h0);
        check("mid_rst_din", bus.Data_din, 16'h0);
        check("mid_rst_rd", bus.Data_rd, 1'b1);
        check("mid_rst_memout", memout, 16'h0);
        check("mid_rst_done", mem_done, 1'b0);
        check("mid_rst_busy", mem_busy, 1'b0);
        last_load = '0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("rst_no_commit", dmem[16'h3100], ref_mem[16'h3100]);
        issue(0, 0, 16'h3010, 16'h0, 0, 1);
        drain();

`ifdef LC3_MEM_TIMEOUT_EN
        wait_n = 1000;
        @(negedge clk);
        mem_start = 1'b1; mem_store = 1'b0; Mem_Control = 1'b0; M_addr = 16'h3010;
        err_cyc = cyc + 17;
        @(negedge clk);
        mem_start = 1'b0;
        repeat (20) @(negedge clk);
        #1;
        check("timeout_idle", mem_busy, 1'b0);
        check("timeout_memout", memout, last_load);
        issue(0, 0, 16'h3030, 16'h0, 1, 1);
        drain();
`else
        issue(0, 1, 16'h3030, 16'h0, 20, 1);
        drain();
`endif

        check("sb_empty", sbq.size(), 0);
        check("wq_empty", wq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/lc3_mem_access.md
# lc3_mem_access

Memory-access stage of the LC3 pipeline: the initiator side of the data-memory port (`Data_addr`/`Data_din`/`Data_rd`/`Data_dout`/`complete_data`), whose responder is the bench memory model. It takes one load/store request from execute and runs the required memory phases, one direct phase or an indirect pointer fetch plus a data phase. It then returns load data to writeback and holds the controller stalled while the access is in flight.

## Interface
- `TIMEOUT_CYCLES`, default 16: wait cycles allowed per phase before abort (used only with timeout feature).
- Reset is asynchronous, active-low.
- `clk`  in  1  pipeline clock; all state changes on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `mem_start`  in  1  one-cycle request pulse from execute (LD/LDR/LDI/ST/STR/STI).
- `mem_store`  in  1  1 = store (ST/STR/STI), 0 = load.
- `Mem_Control`  in  1  1 = indirect (LDI/STI), 0 = direct.
- `M_addr`  in  16  effective address from execute.
- `M_data`  in  16  store data.
- `Data_dout`  in  16  read data from memory.
- `complete_data`  in  1  memory phase complete.
- `Data_addr`  out  16  memory address.
- `Data_din`  out  16  write data.
- `Data_rd`  out  1  1 = read, 0 = write.
- `memout`  out  16  load result to writeback.
- `mem_done`  out  1  one-cycle completion pulse.
- `mem_busy`  out  1  stall request to controller.
- `mem_error`  out  1  sticky timeout flag (0 when feature compiled out).

## Operation
- States: IDLE, IND_RD, RD, WR, DONE. Encoding lives in the package.
- IDLE: on `mem_start`, latch `M_addr`, `M_data`, `mem_store`. Next state is IND_RD if `Mem_Control`=1, else WR if store, else RD.
- IND_RD: `Data_rd`=1, `Data_addr`=latched `M_addr`. On `complete_data`, latch `Data_dout` as pointer, then go to WR (store) or RD (load) with `Data_addr`=pointer. The pointer is used verbatim; no arithmetic.
- RD: `Data_rd`=1. On `complete_data`, `memout`<=`Data_dout` and go to DONE.
- WR: `Data_rd`=0, `Data_din`=latched `M_data`. On `complete_data`, go to DONE. `memout` is unchanged.
- DONE: `mem_done`=1 for exactly one cycle, then IDLE.
- `Data_rd` is 0 only in WR. A low `Data_rd` commits a write at the responder, so idle and all other states hold it at 1.
- `mem_busy`=1 in IND_RD, RD, WR; 0 in IDLE and DONE.
- `mem_start` outside IDLE is ignored; there is no queueing.
- `complete_data` in IDLE or DONE is ignored.
- `memout` holds its last load value until the next load completes.
- Reset (asynchronous, any state, including mid-phase): state IDLE, `Data_addr`=0, `Data_din`=0, `Data_rd`=1, `memout`=0, `mem_done`=0, `mem_busy`=0, `mem_error`=0. A partially completed indirect access is discarded.

## Timing
- All outputs are registered.
- With `complete_data` high on the first phase cycle:
  - LD/ST: `mem_start` sampled at edge N; phase during cycle N+1; `mem_done` during N+2.
  - LDI/STI: `mem_done` during N+3.
- Each wait cycle (`complete_data` low) extends the phase by one cycle.
- `Data_addr`/`Data_din`/`Data_rd` are stable for the whole phase. They change only on the edge that samples `complete_data`=1.
- The earliest next `mem_start` is accepted in DONE+1, i.e. in IDLE.

## Configuration
- `LC3_MEM_TIMEOUT_EN` defined: per-phase wait counter.
  - Cleared on phase entry; increments each cycle `complete_data`=0.
  - On reaching `TIMEOUT_CYCLES`, set `mem_error` (sticky until reset) and go to IDLE without `mem_done`. `memout` is not updated.
- `LC3_MEM_TIMEOUT_EN` not defined: no counter, a phase waits indefinitely, `mem_error` is tied 0.

## Structure
- Package `lc3_mem_pkg`: state enum, `LC3_WORD_W`=16, reset-value constants.
- Optional sub-module `lc3_mem_watchdog`: counter plus compare, instantiated only under `LC3_MEM_TIMEOUT_EN`.
- The rest is a single FSM with its datapath registers.

## Test plan
- LD direct: `M_addr`=0x3010, memory[0x3010]=0xBEEF, zero wait -> `Data_rd`=1, `Data_addr`=0x3010; `memout`=0xBEEF with `mem_done` 2 cycles after start.
- STI: `M_addr`=0x3020, memory[0x3020]=0x4000, `M_data`=0x1234 -> read of 0x3020, then write phase with `Data_addr`=0x4000, `Data_din`=0x1234, `Data_rd`=0; `mem_done` at N+3.
- Wait states on LDI: `complete_data` low for 3 cycles in each phase -> addresses held stable, `mem_busy`=1 throughout, `mem_done` at N+9, `memout` correct.
- `mem_start` pulsed during RD with a different `M_addr` -> ignored; the original access completes unchanged.
- Reset asserted mid-WR -> all outputs immediately at reset values; the next LD after release operates normally.
- `LC3_MEM_TIMEOUT_EN` defined, `TIMEOUT_CYCLES`=16, `complete_data` held 0 -> `mem_error`=1 after 16 wait cycles, back to IDLE, no `mem_done`.
